// File: rtl/arith_pkg.sv
// Shared types for the arithmetic output stages: buffer state, status-bit indices and the
// buffered entry format.
package arith_pkg;

  localparam int unsigned RESULT_BITS = 32;
  localparam int unsigned STATUS_W    = 4;

  localparam int unsigned ST_ERR  = 3;
  localparam int unsigned ST_NEG  = 2;
  localparam int unsigned ST_ZERO = 1;
  localparam int unsigned ST_ONES = 0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [RESULT_BITS-1:0] result;
    logic [STATUS_W-1:0]    status;
  } entry_t;

endpackage

// File: rtl/status_flags.sv
// Combinational entry formation: error beats are sanitised to a zero result carrying only ERR.
module status_flags
  import arith_pkg::*;
#(
  parameter int unsigned BITS = RESULT_BITS
) (
  input  logic [BITS-1:0]     i_result,
  input  logic                i_error,
  output logic [BITS-1:0]     o_result,
  output logic [STATUS_W-1:0] o_status
);

  always_comb begin
    o_result = '0;
    o_status = '0;
    if (i_error) begin
      o_status[ST_ERR] = 1'b1;
    end else begin
      o_result          = i_result;
      o_status[ST_NEG]  = i_result[BITS-1];
      o_status[ST_ZERO] = (i_result == '0);
      o_status[ST_ONES] = (i_result == '1);
    end
  end

endmodule

// File: rtl/result_status_stage.sv
// Two-entry skid-buffered result stage with status flags and a saturating error counter.
// The buffered entry type fixes the data width at RESULT_BITS; BITS must match it.
module result_status_stage
  import arith_pkg::*;
#(
  parameter int unsigned BITS  = RESULT_BITS,
  parameter int unsigned CNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rsn,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [BITS-1:0]     i_result,
  input  logic                i_error,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [BITS-1:0]     o_result,
  output logic [STATUS_W-1:0] o_status,
  input  logic                i_clr_cnt,
  output logic [CNT_W-1:0]    o_err_cnt
);

  buf_state_e r_state, w_state_nxt;
  entry_t     r_out, w_out_nxt;
  entry_t     r_skid, w_skid_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic                w_accept;
  logic                w_consume;
  entry_t              w_new;
  logic [BITS-1:0]     w_new_result;
  logic [STATUS_W-1:0] w_new_status;

  status_flags #(
    .BITS(BITS)
  ) u_status_flags (
    .i_result(i_result),
    .i_error (i_error),
    .o_result(w_new_result),
    .o_status(w_new_status)
  );

  assign w_new     = '{result: w_new_result, status: w_new_status};
  assign o_ready   = (r_state != StTwo);
  assign o_valid   = (r_state != StEmpty);
  assign w_accept  = i_valid && o_ready;
  assign w_consume = o_valid && i_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_state_nxt = StOne;
          w_out_nxt   = w_new;
        end
      end
      StOne: begin
        if (w_accept && w_consume) begin
          w_out_nxt = w_new;
        end else if (w_accept) begin
          w_state_nxt = StTwo;
          w_skid_nxt  = w_new;
        end else if (w_consume) begin
          w_state_nxt = StEmpty;
        end
      end
      StTwo: begin
        if (w_consume) begin
          w_state_nxt = StOne;
          w_out_nxt   = r_skid;
        end
      end
      default: w_state_nxt = StEmpty;
    endcase
  end

  // Clear wins over a same-cycle error accept; saturate rather than wrap.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr_cnt) begin
      w_cnt_nxt = '0;
    end else if (w_accept && i_error && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      r_state <= StEmpty;
      r_out   <= '0;
      r_skid  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_skid  <= w_skid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_result  = r_out.result;
  assign o_status  = r_out.status;
  assign o_err_cnt = r_cnt;

endmodule

// File: tb/tb_result_status_stage.sv
// Directed bench for result_status_stage: main instance (CNT_W=8) plus a CNT_W=2 instance
// for counter saturation.
module tb_result_status_stage;

  logic        clk;
  logic        rsn;
  logic        valid, ready_o, error, valid_o, ready, clr;
  logic [31:0] result, result_o;
  logic [3:0]  status_o;
  logic [7:0]  cnt_o;

  logic        b_valid, b_ready_o, b_error, b_valid_o, b_clr;
  logic [31:0] b_result, b_result_o;
  logic [3:0]  b_status_o;
  logic [1:0]  b_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  result_status_stage #(
    .BITS (32),
    .CNT_W(8)
  ) dut (
    .i_clk    (clk),
    .i_rsn    (rsn),
    .i_valid  (valid),
    .o_ready  (ready_o),
    .i_result (result),
    .i_error  (error),
    .o_valid  (valid_o),
    .i_ready  (ready),
    .o_result (result_o),
    .o_status (status_o),
    .i_clr_cnt(clr),
    .o_err_cnt(cnt_o)
  );

  result_status_stage #(
    .BITS (32),
    .CNT_W(2)
  ) dut_sat (
    .i_clk    (clk),
    .i_rsn    (rsn),
    .i_valid  (b_valid),
    .o_ready  (b_ready_o),
    .i_result (b_result),
    .i_error  (b_error),
    .o_valid  (b_valid_o),
    .i_ready  (1'b1),
    .o_result (b_result_o),
    .o_status (b_status_o),
    .i_clr_cnt(b_clr),
    .o_err_cnt(b_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rsn = 1'b0; valid = 1'b0; error = 1'b0; ready = 1'b1; clr = 1'b0; result = '0;
    b_valid = 1'b0; b_error = 1'b0; b_clr = 1'b0; b_result = 32'h1234_5678;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_result", result_o, 0);
    check("rst_status", status_o, 0);
    check("rst_cnt", cnt_o, 0);
    rsn = 1'b1;
    #5;

    // 1: plain positive value, one-cycle latency
    valid = 1'b1; result = 32'h0000_0005;
    tick();
    check("t1_valid", valid_o, 1);
    check("t1_result", result_o, 5);
    check("t1_status", status_o, 4'b0000);
    check("t1_ready", ready_o, 1);

    // 2: all-ones sets NEG and ONES, zero sets ZERO
    result = 32'hFFFF_FFFF;
    tick();
    check("t2_ones_result", result_o, 32'hFFFF_FFFF);
    check("t2_ones_status", status_o, 4'b0101);
    result = 32'h0;
    tick();
    check("t2_zero_status", status_o, 4'b0010);
    result = 32'h8000_0000;
    tick();
    check("t2_neg_status", status_o, 4'b0100);

    // 3: error beat is sanitised
    error = 1'b1; result = 32'hDEAD_BEEF;
    tick();
    check("t3_result", result_o, 0);
    check("t3_status", status_o, 4'b1000);
    check("t3_cnt", cnt_o, 1);
    error = 1'b0; valid = 1'b0;
    tick();
    check("t3_drain_valid", valid_o, 0);

    // 4: stall with three beats, then drain in order
    ready = 1'b0; valid = 1'b1; result = 32'd1;
    tick();
    check("t4_one_valid", valid_o, 1);
    check("t4_one_ready", ready_o, 1);
    check("t4_a_out", result_o, 1);
    result = 32'd2;
    tick();
    check("t4_two_ready", ready_o, 0);
    check("t4_two_out", result_o, 1);
    result = 32'd3;
    tick();
    check("t4_hold_ready", ready_o, 0);
    check("t4_hold_out", result_o, 1);
    ready = 1'b1;
    tick();
    check("t4_b_out", result_o, 2);
    check("t4_b_ready", ready_o, 1);
    tick();
    check("t4_c_out", result_o, 3);
    check("t4_c_valid", valid_o, 1);
    valid = 1'b0;
    tick();
    check("t4_empty_valid", valid_o, 0);
    check("t4_cnt_kept", cnt_o, 1);

    // 5: saturation on CNT_W=2 instance, then clear beating a same-cycle error
    b_valid = 1'b1; b_error = 1'b1;
    tick(); check("t5_cnt1", b_cnt_o, 1);
    tick(); check("t5_cnt2", b_cnt_o, 2);
    tick(); check("t5_cnt3", b_cnt_o, 3);
    tick(); check("t5_sat4", b_cnt_o, 3);
    tick(); check("t5_sat5", b_cnt_o, 3);
    b_clr = 1'b1;
    tick();
    check("t5_clr", b_cnt_o, 0);
    check("t5_clr_status", b_status_o, 4'b1000);
    b_clr = 1'b0; b_valid = 1'b0; b_error = 1'b0;

    // 6: fill to TWO, then asynchronous reset between edges
    ready = 1'b0; valid = 1'b1; result = 32'd7;
    tick();
    result = 32'd8;
    tick();
    check("t6_two_ready", ready_o, 0);
    #3;
    rsn = 1'b0;
    #1;
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_result", result_o, 0);
    check("t6_rst_cnt", cnt_o, 0);
    check("t6_rst_ready", ready_o, 1);
    check("t6_rst_bcnt", b_cnt_o, 0);
    valid = 1'b1; ready = 1'b1; result = 32'd9;
    #2;
    rsn = 1'b1;
    tick();
    check("t6_after_result", result_o, 9);
    check("t6_after_status", status_o, 4'b0000);
    check("t6_after_valid", valid_o, 1);
    valid = 1'b0;
    tick();
    check("t6_after_empty", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
